// File: rtl/uart_rx_oversampled.sv
// UART receiver: recovers 8N1/8E1/8O1 frames from a 16x oversampled line.
// Ports:
//   clk, rst           system clock, synchronous active-high reset
//   s_tick             oversampling strobe, OVERSAMPLE per bit period
//   rx                 asynchronous serial input, idles high
//   host_acknowledged  host has consumed data_out
//   data_out           last delivered byte
//   host_interrupt     a byte is waiting for the host
//   err                {overrun, parity, framing}
module uart_rx_oversampled #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_tick,
    input  logic                 rx,
    input  logic                 host_acknowledged,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 host_interrupt,
    output logic [2:0]           err
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS) + 1;

    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK_WAIT
    } state_t;

    state_t state;
    state_t state_nx;

    logic                 rx_meta;
    logic                 rx_s;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_err;

    logic bit_tick;
    logic shift_en;
    logic par_take;
    logic stop_take;

    // Two-flop synchronizer; reset to the idle line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (!rx_s) state_nx = START;
            end
            START: begin
                // Mid-bit recheck rejects short glitches.
                if (s_tick && tick_cnt == TICK_MID)
                    state_nx = rx_s ? IDLE : DATA;
            end
            DATA: begin
                if (bit_tick && bit_cnt == BIT_LAST)
                    state_nx = PARITY_EN ? PARITY : STOP;
            end
            PARITY: begin
                if (bit_tick) state_nx = STOP;
            end
            STOP: begin
                // A low stop bit may be a break; wait for idle.
                if (bit_tick)
                    state_nx = rx_s ? IDLE : BREAK_WAIT;
            end
            BREAK_WAIT: begin
                if (rx_s) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Sample strobes.
    always_comb begin
        bit_tick  = s_tick && (tick_cnt == TICK_LAST);
        shift_en  = bit_tick && (state == DATA);
        par_take  = bit_tick && (state == PARITY);
        stop_take = bit_tick && (state == STOP);
    end

    // Counters restart on every state change so each phase
    // measures from its own entry point.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
        end else if (state_nx != state) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            if (s_tick) begin
                tick_cnt <= (tick_cnt == TICK_LAST) ?
                            '0 : tick_cnt + TW'(1);
            end
            if (shift_en) begin
                bit_cnt <= bit_cnt + BW'(1);
            end
        end
    end

    // LSB arrives first, so shifting in at the MSB leaves it at bit 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg   <= '0;
            par_err <= 1'b0;
        end else begin
            if (shift_en)
                shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            if (par_take)
                par_err <= ((^shreg) ^ rx_s) != PARITY_ODD;
        end
    end

    // Host side: delivery wins over a same-cycle ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out       <= '0;
            host_interrupt <= 1'b0;
            err            <= 3'b000;
        end else if (stop_take) begin
            if (!host_interrupt || host_acknowledged) begin
                data_out       <= shreg;
                err            <= {1'b0, PARITY_EN & par_err, ~rx_s};
                host_interrupt <= 1'b1;
            end else begin
                err[2] <= 1'b1;
            end
        end else if (host_interrupt && host_acknowledged) begin
            host_interrupt <= 1'b0;
            err            <= 3'b000;
        end
    end

endmodule
